sram_1w1r_fwd: RTL

Parametrised single-clock 1-write/1-read SRAM with byte-granular write mask, for the core's register-bank and shared-memory arrays. It adds four behaviours to the existing per-array generated memories:
- write-first forwarding on same-address read/write collisions;
- a read-data hold register;
- an optional second output pipeline stage;
- a post-reset zero-initialisation sequencer.

---
 rtl/sram_pkg.sv | 56 +++++
 rtl/sram_init_ctrl.sv | 57 +++++
 rtl/sram_1w1r_fwd.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_pkg
// Purpose  : Shared types, lane-merge helper and parameter legality check
//            for the 1W1R forwarding SRAM.
// Revision : 1.0
// ============================================================================
package sram_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Widest word the lane-merge helper can handle; callers zero-extend.
    localparam int unsigned MAX_DATA_W = 2048;
    localparam int unsigned MAX_IDX_W  = $clog2(MAX_DATA_W);

    typedef logic [MAX_DATA_W-1:0] word_ext_t;

    // Bit i of the result comes from new_word when mask lane (i / gran) is set.
    function automatic word_ext_t lane_merge(
        input word_ext_t   old_word,
        input word_ext_t   new_word,
        input word_ext_t   mask,
        input int unsigned gran
    );
        word_ext_t            res;
        logic [MAX_IDX_W-1:0] bit_idx;
        logic [MAX_IDX_W-1:0] lane_idx;
        res = old_word;
        if (gran != 0) begin
            for (int i = 0; i < MAX_DATA_W; i++) begin
                bit_idx  = MAX_IDX_W'(i);
                lane_idx = MAX_IDX_W'(32'(i) / gran);
                if (mask[lane_idx]) begin
                    res[bit_idx] = new_word[bit_idx];
                end
            end
        end
        return res;
    endfunction

    function automatic bit params_legal(
        input int unsigned latency,
        input int unsigned data_w,
        input int unsigned gran
    );
        return ((latency == 1) || (latency == 2)) &&
               (gran != 0) && (data_w != 0) &&
               ((data_w % gran) == 0) &&
               (data_w <= MAX_DATA_W);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_init_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_init_ctrl
// Purpose  : INIT/RUN control FSM with the post-reset zero-clear counter.
// Revision : 1.0
// ============================================================================
module sram_init_ctrl
    import sram_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned ADDR_W    = $clog2(DEPTH),
    parameter bit          INIT_ZERO = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              init_busy,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] c_last_addr   = ADDR_W'(DEPTH - 1);
    localparam state_e            c_reset_state = INIT_ZERO ? INIT : RUN;

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == INIT) begin
            if (cnt_q == c_last_addr) begin
                state_d = RUN;
                cnt_d   = '0;
            end else begin
                cnt_d   = cnt_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= c_reset_state;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign init_busy = (state_q == INIT);
    assign clr_en    = (state_q == INIT);
    assign clr_addr  = cnt_q;

endmodule
`default_nettype wire

// File: rtl/sram_1w1r_fwd.sv
`default_nettype none
// ============================================================================
// Module   : sram_1w1r_fwd
// Purpose  : 1W1R byte-masked SRAM with write-first forwarding, read-data
//            hold, optional second output stage and zero-init sequencer.
// Revision : 1.0
// ============================================================================
module sram_1w1r_fwd
    import sram_pkg::*;
#(
    parameter int unsigned DATA_W    = 1024,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned ADDR_W    = $clog2(DEPTH),
    parameter int unsigned MASK_GRAN = 8,
    parameter int unsigned MASK_W    = DATA_W / MASK_GRAN,
    parameter int unsigned LATENCY   = 1,
    parameter bit          INIT_ZERO = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              init_busy,
    input  logic              W_en,
    input  logic [ADDR_W-1:0] W_addr,
    input  logic [DATA_W-1:0] W_data,
    input  logic [MASK_W-1:0] W_mask,
    input  logic              R_en,
    input  logic [ADDR_W-1:0] R_addr,
    output logic [DATA_W-1:0] R_data,
    output logic              R_valid
);

    localparam logic [ADDR_W:0] c_depth_ext = (ADDR_W + 1)'(DEPTH);

    if (!params_legal(LATENCY, DATA_W, MASK_GRAN) || (MASK_W != DATA_W / MASK_GRAN)) begin : g_param_check
        $error("sram_1w1r_fwd: illegal LATENCY / DATA_W / MASK_GRAN / MASK_W combination");
    end

    logic              clr_en;
    logic [ADDR_W-1:0] clr_addr;

    logic [DATA_W-1:0] ram_q [DEPTH];

    logic              w_run;
    logic              w_wr_in_range;
    logic              w_rd_in_range;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [DATA_W-1:0] w_wr_word;
    logic              w_collide;
    logic              w_rd_fire;
    logic [DATA_W-1:0] w_rd_word;
    word_ext_t         w_old_ext;
    word_ext_t         w_new_ext;
    word_ext_t         w_mask_ext;
    word_ext_t         w_merged_ext;

    sram_init_ctrl #(
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .INIT_ZERO (INIT_ZERO)
    ) u_init_ctrl (
        .clock     (clock),
        .reset_n   (reset_n),
        .init_busy (init_busy),
        .clr_en    (clr_en),
        .clr_addr  (clr_addr)
    );

    assign w_run         = ~init_busy;
    assign w_wr_in_range = ({1'b0, W_addr} < c_depth_ext);
    assign w_rd_in_range = ({1'b0, R_addr} < c_depth_ext);

    // Clear sequencer owns the write port during INIT; user writes only in RUN.
    always_comb begin
        w_old_ext    = '0;
        w_new_ext    = '0;
        w_mask_ext   = '0;
        w_merged_ext = '0;
        w_wr_en      = 1'b0;
        w_wr_addr    = W_addr;
        w_wr_word    = '0;
        if (clr_en) begin
            w_wr_en   = 1'b1;
            w_wr_addr = clr_addr;
        end else if (W_en && w_wr_in_range) begin
            w_old_ext[DATA_W-1:0]  = ram_q[W_addr];
            w_new_ext[DATA_W-1:0]  = W_data;
            w_mask_ext[MASK_W-1:0] = W_mask;
            w_merged_ext           = lane_merge(w_old_ext, w_new_ext, w_mask_ext, MASK_GRAN);
            w_wr_en                = |W_mask;
            w_wr_word              = w_merged_ext[DATA_W-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            ram_q[w_wr_addr] <= w_wr_word;
        end
    end

    // On a same-address collision the merged write word is exactly the
    // write-first read result, so the forwarding path reuses it.
    assign w_collide = w_run && W_en && w_wr_in_range && (W_addr == R_addr);
    assign w_rd_fire = w_run && R_en;

    always_comb begin
        w_rd_word = '0;
        if (w_collide) begin
            w_rd_word = w_merged_ext[DATA_W-1:0];
        end else if (w_rd_in_range) begin
            w_rd_word = ram_q[R_addr];
        end
    end

    logic [DATA_W-1:0] s1_data_q;
    logic [DATA_W-1:0] s1_data_d;
    logic              s1_valid_q;
    logic              s1_valid_d;

    always_comb begin
        s1_valid_d = w_rd_fire;
        s1_data_d  = w_rd_fire ? w_rd_word : s1_data_q;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_data_q  <= s1_data_d;
            s1_valid_q <= s1_valid_d;
        end
    end

    if (LATENCY == 2) begin : g_lat2
        logic [DATA_W-1:0] s2_data_q;
        logic [DATA_W-1:0] s2_data_d;
        logic              s2_valid_q;
        logic              s2_valid_d;

        always_comb begin
            s2_valid_d = s1_valid_q;
            s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
        end

        always_ff @(posedge clock) begin
            if (!reset_n) begin
                s2_data_q  <= '0;
                s2_valid_q <= 1'b0;
            end else begin
                s2_data_q  <= s2_data_d;
                s2_valid_q <= s2_valid_d;
            end
        end

        assign R_data  = s2_data_q;
        assign R_valid = s2_valid_q;
    end else begin : g_lat1
        assign R_data  = s1_data_q;
        assign R_valid = s1_valid_q;
    end

endmodule
`default_nettype wire
